// File: rtl/shift_row_pipe.sv
// shift_row_pipe: registered Rijndael ShiftRows/InvShiftRows stage (NB=4/6/8) behind a 2-entry valid/ready buffer.
//   Ports: clk, rst (sync, active-high); in_valid/in_ready/in_inv/in_data [0:W-1] (byte (r,c) at 8*(4c+r));
//   out_valid/out_ready/out_inv/out_data (head entry of the buffer, registered).
//   Optional SHIFT_ROW_PIPE_BYPASS_EN adds in_byp (store data untransformed) and out_byp (echo).
module shift_row_pipe #(
  parameter int NB = 4,
  localparam int W = NB * 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [0:W-1] in_data,
`ifdef SHIFT_ROW_PIPE_BYPASS_EN
  input  logic         in_byp,
  output logic         out_byp,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_inv,
  output logic [0:W-1] out_data
);
`ifdef SHIFT_ROW_PIPE_BYPASS_EN
  localparam int E = W + 2;
`else
  localparam int E = W + 1;
`endif
  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_row_pipe: NB must be 4, 6 or 8");
  end
  // Row offsets: {0,1,2,3} for NB=4/6, {0,1,3,4} for NB=8.
  function automatic int sh(input int r);
    return (NB == 8 && r > 1) ? r + 1 : r;
  endfunction
  logic [0:W-1] xf;
  logic [E-1:0] ent;
  logic [E-1:0] mem_q [2];
  logic [E-1:0] mem_d [2];
  logic [1:0]   count_q, count_d;
  logic         head_q, head_d, tail_q, tail_d, ready_q, ready_d, acc, drn;
  always_comb begin
    xf = '0;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        xf[8*(4*c+r) +: 8] = in_data[8*(4*(in_inv ? (c - sh(r) + NB) % NB : (c + sh(r)) % NB) + r) +: 8];
  end
`ifdef SHIFT_ROW_PIPE_BYPASS_EN
  assign ent = {in_byp, in_inv, in_byp ? in_data : xf};
  assign out_byp = mem_q[head_q][W+1];
`else
  assign ent = {in_inv, xf};
`endif
  always_comb begin
    acc = in_valid && ready_q;
    drn = (count_q != 2'd0) && out_ready;
    count_d = count_q + {1'b0, acc} - {1'b0, drn};
    head_d = head_q ^ drn;
    tail_d = tail_q ^ acc;
    ready_d = count_d != 2'd2;
    mem_d[0] = (acc && !tail_q) ? ent : mem_q[0];
    mem_d[1] = (acc && tail_q) ? ent : mem_q[1];
  end
  // Storage is cleared on reset so the outputs read zero right after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      ready_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
      ready_q <= ready_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end
  assign in_ready = ready_q;
  assign out_valid = count_q != 2'd0;
  assign out_inv = mem_q[head_q][W];
  assign out_data = mem_q[head_q][W-1:0];
endmodule

// File: tb/tb_shift_row_pipe.sv
// tb_shift_row_pipe: randomized and directed checks of shift_row_pipe against a row-rotation reference model.
module tb_shift_row_pipe;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
  logic [0:127] in_data = '0;
  logic in_ready, out_valid, out_inv;
  logic [0:127] out_data;
  logic v68 = 1'b0, inv68 = 1'b0;
  logic [0:255] d8_in = '0, d8_out;
  logic [0:191] d6_in = '0, d6_out;
  logic r8, r6, ov8, ov6, oi8, oi6;
  int n_cmp = 0, n_err = 0, n_drain = 0;
  typedef struct { logic [0:127] d; logic inv; } beat_t;
  beat_t sb [$];
  always #5 clk = ~clk;
`ifdef SHIFT_ROW_PIPE_BYPASS_EN
  logic ob4, ob6, ob8;
  shift_row_pipe #(.NB(4)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .in_byp(1'b0), .out_byp(ob4), .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .out_data(out_data));
  shift_row_pipe #(.NB(8)) d8 (.clk(clk), .rst(rst), .in_valid(v68), .in_ready(r8), .in_inv(inv68),
    .in_data(d8_in), .in_byp(1'b0), .out_byp(ob8), .out_valid(ov8), .out_ready(1'b1), .out_inv(oi8), .out_data(d8_out));
  shift_row_pipe #(.NB(6)) d6 (.clk(clk), .rst(rst), .in_valid(v68), .in_ready(r6), .in_inv(inv68),
    .in_data(d6_in), .in_byp(1'b0), .out_byp(ob6), .out_valid(ov6), .out_ready(1'b1), .out_inv(oi6), .out_data(d6_out));
`else
  shift_row_pipe #(.NB(4)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .out_data(out_data));
  shift_row_pipe #(.NB(8)) d8 (.clk(clk), .rst(rst), .in_valid(v68), .in_ready(r8), .in_inv(inv68),
    .in_data(d8_in), .out_valid(ov8), .out_ready(1'b1), .out_inv(oi8), .out_data(d8_out));
  shift_row_pipe #(.NB(6)) d6 (.clk(clk), .rst(rst), .in_valid(v68), .in_ready(r6), .in_inv(inv68),
    .in_data(d6_in), .out_valid(ov6), .out_ready(1'b1), .out_inv(oi6), .out_data(d6_out));
`endif
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Reference: each row r is rotated left by s_r (forward) or by nb-s_r (inverse); data left-aligned in 256 bits.
  function automatic logic [0:255] ref_sr(input logic [0:255] d, input logic inv, input int nb);
    logic [7:0] row [8];
    logic [7:0] t;
    logic [0:255] o;
    int s;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      s = (nb == 8 && r > 1) ? r + 1 : r;
      for (int c = 0; c < nb; c++) row[c] = d[8*(4*c+r) +: 8];
      repeat (inv ? (nb - s) % nb : s) begin
        t = row[0];
        for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
        row[nb-1] = t;
      end
      for (int c = 0; c < nb; c++) o[8*(4*c+r) +: 8] = row[c];
    end
    return o;
  endfunction
  function automatic logic [0:127] ref4(input logic [0:127] d, input logic inv);
    logic [0:255] o;
    o = ref_sr({d, 128'h0}, inv, 4);
    return o[0:127];
  endfunction
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        n_drain++;
        if (sb.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("sb_data", out_data, sb[0].d);
          chk("sb_inv", out_inv, sb[0].inv);
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back('{ref4(in_data, in_inv), in_inv});
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input string tag, input logic [0:127] d, input logic inv, input logic [0:127] exp);
    in_valid = 1'b1; in_data = d; in_inv = inv;
    tick;
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_inv"}, out_inv, inv);
    tick;
  endtask
  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    logic [0:127] a, b, fips_out;
    logic [0:255] asc32, e8;
    int n0, waited;
    tick;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_inv", out_inv, 0);
    rst = 1'b0;
    tick;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    beat("fwd_asc", 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h00050a0f04090e03080d02070c01060b);
    beat("inv_asc", 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 128'h000d0a0704010e0b0805020f0c090603);
    beat("fips_fwd", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    fips_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    beat("fips_inv", fips_out, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230);
    // backpressure
    out_ready = 1'b0; n0 = n_drain;
    a = rnd128(); b = rnd128();
    in_valid = 1'b1; in_inv = 1'b0; in_data = a;
    tick;
    chk("bp_ready1", in_ready, 1);
    in_inv = 1'b1; in_data = b;
    tick;
    chk("bp_ready2", in_ready, 0);
    chk("bp_head", out_data, ref4(a, 1'b0));
    in_inv = 1'b0; in_data = rnd128();
    tick;
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_stable", out_data, ref4(a, 1'b0));
    chk("bp_stable_inv", out_inv, 0);
    out_ready = 1'b1;
    waited = 0;
    while (!in_ready && waited < 5) begin tick; waited++; end
    chk("bp_wait_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    chk("bp_drained", n_drain - n0, 3);
    chk("bp_sb_empty", sb.size(), 0);
    // streaming
    n0 = n_drain;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_inv = i[0]; in_data = rnd128();
      if (i > 0) chk("stream_valid", out_valid, 1);
      chk("stream_ready", in_ready, 1);
      tick;
    end
    in_valid = 1'b0;
    tick;
    chk("stream_count", n_drain - n0, 16);
    // random handshakes
    for (int i = 0; i < 300; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_inv = $urandom_range(0, 1) == 1;
      in_data = rnd128();
      out_ready = $urandom_range(0, 3) != 0;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick;
    chk("rand_sb_empty", sb.size(), 0);
    // reset with two beats buffered
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = rnd128(); tick;
    in_data = rnd128(); tick;
    in_valid = 1'b0;
    chk("full_ready", in_ready, 0);
    rst = 1'b1;
    tick;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_inv", out_inv, 0);
    chk("mid_rst_ready", in_ready, 0);
    rst = 1'b0; out_ready = 1'b1;
    tick;
    chk("mid_post_ready", in_ready, 1);
    chk("mid_post_valid", out_valid, 0);
    repeat (3) tick;
    // NB=8 and NB=6
    asc32 = '0;
    for (int i = 0; i < 32; i++) asc32[8*i +: 8] = i[7:0];
    v68 = 1'b1; inv68 = 1'b0; d8_in = asc32; d6_in = asc32[0:191];
    tick;
    v68 = 1'b0;
    chk("nb8_valid", ov8, 1);
    chk("nb8_col0", d8_out[0:31], 32'h00050e13);
    chk("nb8_col7", d8_out[224:255], 32'h1c010a0f);
    chk("nb6_col0", d6_out[0:31], 32'h00050a0f);
    tick;
    for (int i = 0; i < 8; i++) begin
      v68 = 1'b1; inv68 = i[0];
      d8_in = {rnd128(), rnd128()}; d6_in = d8_in[0:191];
      tick;
      v68 = 1'b0;
      chk("nb8_rand", d8_out, ref_sr(d8_in, inv68, 8));
      chk("nb8_rand_inv", oi8, inv68);
      e8 = ref_sr({d6_in, 64'h0}, inv68, 6);
      chk("nb6_rand", d6_out, e8[0:191]);
      tick;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
